tx_arb_ctrl: RTL and testbench

- Round-robin packet arbiter that shares the single tx_inf transmit port between NUM_REQ upstream requesters in the ppe transmit path.
- Grants are held for a whole packet, from first beat through the beat flagged last.
- Drives tx_inf master-side valid/ready signalling: tx_en out, tx_rdy in.
- A beat watchdog prevents a stuck requester from locking the port.

---
 rtl/tx_arb_ctrl.sv | 87 ++++++++
 tb/tb_tx_arb_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/tx_arb_ctrl.sv
// tx_arb_ctrl: round-robin tx port packet arbiter with beat watchdog (TX_ARB_PRIO_EN makes requester 0 strict-priority)
module tx_arb_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = 32,
  parameter int MAX_BEATS = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_en,
  output logic [DATA_W-1:0]          tx_data,
  output logic                       tx_last,
  input  logic                       tx_rdy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       wdog_err
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BEATS);
`ifdef TX_ARB_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif
  typedef enum logic {IDLE, XFER} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, gid_q, gid_d, rr_sel, sel, idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] g_data;
  logic wdog_q, wdog_d, rr_found, found, prio_win, xfer, beat, at_max, g_last;
  always_comb begin
    rr_sel = ptr_q;
    rr_found = 1'b0;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IW'((int'(ptr_q) + k) % NUM_REQ);
      if (req_valid[idx] && !(PRIO && idx == '0)) begin
        rr_sel = idx;
        rr_found = 1'b1;
      end
    end
    prio_win = PRIO && req_valid[0];
    sel = prio_win ? '0 : rr_sel;
    found = prio_win || rr_found;
  end
  always_comb begin
    g_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gid_q == IW'(i)) g_data = req_data[i*DATA_W +: DATA_W];
  end
  always_comb begin
    xfer = state_q == XFER;
    at_max = cnt_q == CW'(MAX_BEATS - 1);
    g_last = req_last[gid_q];
    tx_en = xfer && req_valid[gid_q];
    tx_data = xfer ? g_data : '0;
    tx_last = xfer && (g_last || at_max);
    req_ready = xfer ? NUM_REQ'(tx_rdy) << gid_q : '0;
    beat = tx_en && tx_rdy;
    state_d = xfer ? ((beat && tx_last) ? IDLE : XFER) : (found ? XFER : IDLE);
    gid_d = (!xfer && found) ? sel : gid_q;
    ptr_d = (!xfer && found && !prio_win) ? sel : ptr_q;
    cnt_d = xfer ? cnt_q + CW'(beat) : '0;
    wdog_d = beat && at_max && !g_last;
  end
  assign busy = state_q == XFER;
  assign grant_id = gid_q;
  assign wdog_err = wdog_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q <= IW'(NUM_REQ - 1);
      gid_q <= '0;
      cnt_q <= '0;
      wdog_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      gid_q <= gid_d;
      cnt_q <= cnt_d;
      wdog_q <= wdog_d;
    end
  end
endmodule

// File: tb/tb_tx_arb_ctrl.sv
// tb_tx_arb_ctrl: table-driven and sequence checks of tx_arb_ctrl with MAX_BEATS=4
module tb_tx_arb_ctrl;
`ifdef TX_ARB_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0, tx_rdy = 1'b0;
  logic [3:0] req_valid = '0, req_last = '0, req_ready;
  logic [127:0] req_data = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
  logic tx_en, tx_last, busy, wdog_err;
  logic [31:0] tx_data;
  logic [1:0] grant_id;
  int n_cmp = 0, n_bad = 0;
  typedef struct {
    logic rst;
    logic [3:0] v;
    logic [3:0] l;
    logic rdy;
    logic en;
    logic last;
    logic busy;
    logic [1:0] gid;
    logic [3:0] rr;
    logic wd;
  } vec_t;
  vec_t tv[$];
  tx_arb_ctrl #(.NUM_REQ(4), .DATA_W(32), .MAX_BEATS(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_en(tx_en), .tx_data(tx_data), .tx_last(tx_last), .tx_rdy(tx_rdy),
    .grant_id(grant_id), .busy(busy), .wdog_err(wdog_err)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(logic r, logic [3:0] v, logic [3:0] l, logic rdy, logic en, logic last,
                              logic b, logic [1:0] gid, logic [3:0] rr, logic wd);
    vec_t t;
    t.rst = r; t.v = v; t.l = l; t.rdy = rdy; t.en = en; t.last = last;
    t.busy = b; t.gid = gid; t.rr = rr; t.wd = wd;
    return t;
  endfunction
  task automatic chk(string name, logic [63:0] got, logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask
  initial begin
    logic [1:0] a, c;
    logic [3:0] ra, rc;
    int nb;
    bit done;
    a = PRIO ? 2'd0 : 2'd3;
    c = PRIO ? 2'd0 : 2'd3;
    ra = 4'b0001 << a;
    rc = 4'b0001 << c;
    tv.push_back(mk(0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 4'h0, 0));
    tv.push_back(mk(1, 4'b0100, 4'h0, 1, 0, 0, 0, 0, 4'h0, 0));
    tv.push_back(mk(1, 4'b0100, 4'h0, 1, 1, 0, 1, 2, 4'b0100, 0));
    tv.push_back(mk(1, 4'b0100, 4'h0, 1, 1, 0, 1, 2, 4'b0100, 0));
    tv.push_back(mk(1, 4'b0100, 4'b0100, 1, 1, 1, 1, 2, 4'b0100, 0));
    tv.push_back(mk(1, 4'h0, 4'h0, 1, 0, 0, 0, 2, 4'h0, 0));
    tv.push_back(mk(0, 4'h0, 4'h0, 1, 0, 0, 0, 2, 4'h0, 0));
    tv.push_back(mk(1, 4'hF, 4'hF, 1, 0, 0, 0, 0, 4'h0, 0));
    tv.push_back(mk(1, 4'hF, 4'hF, 1, 1, 1, 1, 0, 4'b0001, 0));
    tv.push_back(mk(1, 4'hF, 4'hF, 1, 0, 0, 0, 0, 4'h0, 0));
    tv.push_back(mk(1, 4'hF, 4'hF, 1, 1, 1, 1, 1, 4'b0010, 0));
    tv.push_back(mk(1, 4'hF, 4'hF, 1, 0, 0, 0, 1, 4'h0, 0));
    tv.push_back(mk(1, 4'hF, 4'hF, 1, 1, 1, 1, 2, 4'b0100, 0));
    tv.push_back(mk(1, 4'hF, 4'hF, 1, 0, 0, 0, 2, 4'h0, 0));
    tv.push_back(mk(1, 4'hF, 4'hF, 1, 1, 1, 1, 3, 4'b1000, 0));
    tv.push_back(mk(1, 4'hF, 4'hF, 1, 0, 0, 0, 3, 4'h0, 0));
    tv.push_back(mk(1, 4'hF, 4'hF, 1, 1, 1, 1, 0, 4'b0001, 0));
    tv.push_back(mk(1, 4'h0, 4'h0, 1, 0, 0, 0, 0, 4'h0, 0));
    tv.push_back(mk(1, 4'b0010, 4'h0, 0, 0, 0, 0, 0, 4'h0, 0));
    tv.push_back(mk(1, 4'b0010, 4'h0, 0, 1, 0, 1, 1, 4'h0, 0));
    tv.push_back(mk(1, 4'b0010, 4'h0, 1, 1, 0, 1, 1, 4'b0010, 0));
    tv.push_back(mk(1, 4'h0, 4'h0, 1, 0, 0, 1, 1, 4'b0010, 0));
    tv.push_back(mk(1, 4'b0010, 4'b0010, 0, 1, 1, 1, 1, 4'h0, 0));
    tv.push_back(mk(1, 4'b0010, 4'b0010, 0, 1, 1, 1, 1, 4'h0, 0));
    tv.push_back(mk(1, 4'b0010, 4'b0010, 1, 1, 1, 1, 1, 4'b0010, 0));
    tv.push_back(mk(1, 4'h0, 4'h0, 1, 0, 0, 0, 1, 4'h0, 0));
    tv.push_back(mk(1, 4'b0001, 4'h0, 1, 0, 0, 0, 1, 4'h0, 0));
    tv.push_back(mk(1, 4'b0001, 4'h0, 1, 1, 0, 1, 0, 4'b0001, 0));
    tv.push_back(mk(1, 4'b0001, 4'h0, 1, 1, 0, 1, 0, 4'b0001, 0));
    tv.push_back(mk(1, 4'b0001, 4'h0, 1, 1, 0, 1, 0, 4'b0001, 0));
    tv.push_back(mk(1, 4'b0001, 4'h0, 1, 1, 1, 1, 0, 4'b0001, 0));
    tv.push_back(mk(1, 4'b0001, 4'h0, 1, 0, 0, 0, 0, 4'h0, 1));
    tv.push_back(mk(1, 4'b0001, 4'h0, 1, 1, 0, 1, 0, 4'b0001, 0));
    tv.push_back(mk(1, 4'h0, 4'h0, 1, 0, 0, 1, 0, 4'b0001, 0));
    tv.push_back(mk(1, 4'b0001, 4'b0001, 1, 1, 1, 1, 0, 4'b0001, 0));
    tv.push_back(mk(1, 4'h0, 4'h0, 1, 0, 0, 0, 0, 4'h0, 0));
    tv.push_back(mk(1, 4'b0100, 4'h0, 1, 0, 0, 0, 0, 4'h0, 0));
    tv.push_back(mk(1, 4'b0100, 4'h0, 1, 1, 0, 1, 2, 4'b0100, 0));
    tv.push_back(mk(0, 4'b0100, 4'h0, 1, 1, 0, 1, 2, 4'b0100, 0));
    tv.push_back(mk(1, 4'hF, 4'hF, 1, 0, 0, 0, 0, 4'h0, 0));
    tv.push_back(mk(1, 4'hF, 4'hF, 1, 1, 1, 1, 0, 4'b0001, 0));
    tv.push_back(mk(1, 4'h0, 4'h0, 1, 0, 0, 0, 0, 4'h0, 0));
    tv.push_back(mk(1, 4'b1001, 4'b1001, 1, 0, 0, 0, 0, 4'h0, 0));
    tv.push_back(mk(1, 4'b1001, 4'b1001, 1, 1, 1, 1, a, ra, 0));
    tv.push_back(mk(1, 4'b1001, 4'b1001, 1, 0, 0, 0, a, 4'h0, 0));
    tv.push_back(mk(1, 4'b1001, 4'b1001, 1, 1, 1, 1, 0, 4'b0001, 0));
    tv.push_back(mk(1, 4'b1001, 4'b1001, 1, 0, 0, 0, 0, 4'h0, 0));
    tv.push_back(mk(1, 4'b1001, 4'b1001, 1, 1, 1, 1, c, rc, 0));
    tv.push_back(mk(1, 4'b1000, 4'b1000, 1, 0, 0, 0, c, 4'h0, 0));
    tv.push_back(mk(1, 4'b1000, 4'b1000, 1, 1, 1, 1, 3, 4'b1000, 0));
    tv.push_back(mk(1, 4'h0, 4'h0, 1, 0, 0, 0, 3, 4'h0, 0));
    repeat (2) @(posedge clk);
    foreach (tv[i]) begin
      @(negedge clk);
      rst = tv[i].rst; req_valid = tv[i].v; req_last = tv[i].l; tx_rdy = tv[i].rdy;
      #1;
      chk($sformatf("row%0d {en,last,busy,gid,ready,wdog}", i),
          {tx_en, tx_last, busy, grant_id, req_ready, wdog_err},
          {tv[i].en, tv[i].last, tv[i].busy, tv[i].gid, tv[i].rr, tv[i].wd});
      if (tv[i].en)
        chk($sformatf("row%0d tx_data", i), tx_data, 32'h1111_1111 * (32'(tv[i].gid) + 32'd1));
    end
    nb = 0;
    done = 1'b0;
    req_last = '0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      @(negedge clk);
      req_valid = 4'b0010;
      tx_rdy = 1'($urandom_range(0, 1));
      #1;
      if (tx_en && tx_rdy) begin
        chk($sformatf("wdog beat%0d {gid,last,ready}", nb), {grant_id, tx_last, req_ready},
            {2'd1, nb == 3, 4'b0010});
        nb++;
        done = nb == 4;
      end
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wdog timeout: got %0d beats want 4", nb);
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("wdog pulse {wdog,busy}", {wdog_err, busy}, 2'b10);
    @(negedge clk);
    #1;
    chk("wdog one-shot", wdog_err, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
